// File: rtl/regfile_param.sv
// Parametrised register file with two registered read ports, optional write-to-read bypass,
// optional hardwired-zero entry 0 and a one-entry-per-cycle clear sweep.
module regfile_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 2,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              write_enable_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic              read_en_i,
  input  logic [ADDR_W-1:0] read_addr1_i,
  input  logic [ADDR_W-1:0] read_addr2_i,
  output logic [DATA_W-1:0] read_data1_o,
  output logic [DATA_W-1:0] read_data2_o,
  input  logic              clear_req_i,
  output logic              busy_o,
  output logic              write_drop_o
);

  localparam int unsigned       Depth   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(Depth - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy_q, busy_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] mem_q [Depth];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Read value for one port in IDLE; stored is the pre-write array content.
  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] val;
    if (ZERO_REG && (addr == '0)) begin
      val = '0;
    end else if (BYPASS && we && (waddr == addr)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    drop_d    = 1'b0;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    mem_we    = 1'b0;
    mem_waddr = write_addr_i;
    mem_wdata = write_data_i;

    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        drop_d    = write_enable_i;
        if (read_en_i) begin
          rd1_d = '0;
          rd2_d = '0;
        end
        // Compare before increment so the pointer never wraps into a second sweep.
        if (clr_ptr_q == LastPtr) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      StIdle: begin
        if (read_en_i) begin
          rd1_d = read_sel(read_addr1_i, mem_q[read_addr1_i], write_enable_i, write_addr_i,
                           write_data_i);
          rd2_d = read_sel(read_addr2_i, mem_q[read_addr2_i], write_enable_i, write_addr_i,
                           write_data_i);
        end
        if (write_enable_i && !(ZERO_REG && (write_addr_i == '0))) begin
          mem_we = 1'b1;
        end
        if (clear_req_i) begin
          state_d   = StClear;
          clr_ptr_d = '0;
          busy_d    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
      drop_q    <= 1'b0;
      rd1_q     <= '0;
      rd2_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
    end
  end

  // Array has no reset; the sweep that follows reset zeroes it.
  always_ff @(posedge clk_i) begin
    if (rst_ni && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign read_data1_o = rd1_q;
  assign read_data2_o = rd2_q;
  assign busy_o       = busy_q;
  assign write_drop_o = drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations share one stimulus stream and are checked
// every cycle against a countdown/array reference model.
module tb_regfile_param;

  localparam int NCFG  = 3;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we;
  logic [1:0] wa;
  logic [7:0] wd;
  logic       re;
  logic [1:0] ra1;
  logic [1:0] ra2;
  logic       cr;

  logic [7:0] o_rd1  [NCFG];
  logic [7:0] o_rd2  [NCFG];
  logic       o_busy [NCFG];
  logic       o_drop [NCFG];

  // Config 0: defaults; 1: zero reg + bypass; 2: no zero reg, no bypass.
  bit cfg_zr  [NCFG] = '{1'b0, 1'b1, 1'b0};
  bit cfg_byp [NCFG] = '{1'b1, 1'b1, 1'b0};

  logic [7:0] mem    [NCFG][DEPTH];
  logic [7:0] e_rd1  [NCFG];
  logic [7:0] e_rd2  [NCFG];
  logic       e_busy;
  logic       e_drop;
  int         busy_left;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .write_enable_i(we), .write_addr_i(wa), .write_data_i(wd),
    .read_en_i(re), .read_addr1_i(ra1), .read_addr2_i(ra2), .read_data1_o(o_rd1[0]),
    .read_data2_o(o_rd2[0]), .clear_req_i(cr), .busy_o(o_busy[0]), .write_drop_o(o_drop[0])
  );
  regfile_param #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .write_enable_i(we), .write_addr_i(wa), .write_data_i(wd),
    .read_en_i(re), .read_addr1_i(ra1), .read_addr2_i(ra2), .read_data1_o(o_rd1[1]),
    .read_data2_o(o_rd2[1]), .clear_req_i(cr), .busy_o(o_busy[1]), .write_drop_o(o_drop[1])
  );
  regfile_param #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .write_enable_i(we), .write_addr_i(wa), .write_data_i(wd),
    .read_en_i(re), .read_addr1_i(ra1), .read_addr2_i(ra2), .read_data1_o(o_rd1[2]),
    .read_data2_o(o_rd2[2]), .clear_req_i(cr), .busy_o(o_busy[2]), .write_drop_o(o_drop[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input int k, input logic [1:0] a);
    if (cfg_zr[k] && a == 2'd0) return 8'h00;
    if (cfg_byp[k] && we && wa == a) return wd;
    return mem[k][a];
  endfunction

  // Reference: busy_left counts remaining sweep cycles; array held as plain memory.
  task automatic model_step();
    if (!rst_n) begin
      for (int k = 0; k < NCFG; k++) begin
        e_rd1[k] = 8'h00;
        e_rd2[k] = 8'h00;
      end
      e_drop    = 1'b0;
      busy_left = DEPTH;
    end else if (busy_left > 0) begin
      for (int k = 0; k < NCFG; k++) begin
        mem[k][DEPTH - busy_left] = 8'h00;
        if (re) begin
          e_rd1[k] = 8'h00;
          e_rd2[k] = 8'h00;
        end
      end
      e_drop    = we;
      busy_left = busy_left - 1;
    end else begin
      e_drop = 1'b0;
      for (int k = 0; k < NCFG; k++) begin
        if (re) begin
          e_rd1[k] = model_read(k, ra1);
          e_rd2[k] = model_read(k, ra2);
        end
      end
      for (int k = 0; k < NCFG; k++) begin
        if (we && !(cfg_zr[k] && wa == 2'd0)) mem[k][wa] = wd;
      end
      if (cr) busy_left = DEPTH;
    end
    e_busy = (busy_left > 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < NCFG; k++) begin
      check($sformatf("cfg%0d_rd1", k), 32'(o_rd1[k]), 32'(e_rd1[k]));
      check($sformatf("cfg%0d_rd2", k), 32'(o_rd2[k]), 32'(e_rd2[k]));
      check($sformatf("cfg%0d_busy", k), 32'(o_busy[k]), 32'(e_busy));
      check($sformatf("cfg%0d_drop", k), 32'(o_drop[k]), 32'(e_drop));
    end
  endtask

  task automatic drive(input logic w_en, input logic [1:0] w_a, input logic [7:0] w_d,
                       input logic r_en, input logic [1:0] a1, input logic [1:0] a2,
                       input logic c_r);
    we  = w_en;
    wa  = w_a;
    wd  = w_d;
    re  = r_en;
    ra1 = a1;
    ra2 = a2;
    cr  = c_r;
  endtask

  // Ticks until busy drops (bounded); returns the number of ticks taken.
  task automatic run_until_idle(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (o_busy[0] && n < 16);
  endtask

  initial begin
    int n;
    for (int k = 0; k < NCFG; k++) begin
      for (int a = 0; a < DEPTH; a++) mem[k][a] = 8'h00;
    end
    busy_left = DEPTH;
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd1, 1'b0);

    // Reset held two cycles, then sweep of exactly DEPTH cycles.
    tick();
    tick();
    rst_n = 1'b1;
    run_until_idle(n);
    check("reset_busy_len", 32'(n), 32'd4);
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 2'd0, 8'h00, 1'b1, 2'(a), 2'(a), 1'b0);
      tick();
    end

    // Write then read; same-cycle write/read of addr 3.
    drive(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd1, 1'b0);
    tick();
    check("read_a5", 32'(o_rd1[0]), 32'h0A5);
    drive(1'b1, 2'd3, 8'h3C, 1'b1, 2'd3, 2'd3, 1'b0);
    tick();
    check("bypass_on", 32'(o_rd1[0]), 32'h03C);
    check("bypass_off", 32'(o_rd1[2]), 32'h000);

    // Zero register: write 0xFF to addr 0, read back; then same-cycle bypass read.
    drive(1'b1, 2'd0, 8'hFF, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0);
    tick();
    check("zero_reg_rd1", 32'(o_rd1[1]), 32'h000);
    check("zero_reg_rd2", 32'(o_rd2[1]), 32'h000);
    drive(1'b1, 2'd0, 8'hEE, 1'b1, 2'd0, 2'd0, 1'b0);
    tick();
    check("zero_reg_bypass", 32'(o_rd1[1]), 32'h000);

    // Fill, clear, write during sweep is dropped.
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, 2'(a), 8'((a + 1) * 8'h11), 1'b0, 2'd0, 2'd0, 1'b0);
      tick();
    end
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd2, 1'b1);
    tick();
    check("pre_clear_rd1", 32'(o_rd1[0]), 32'h044);
    drive(1'b1, 2'd1, 8'h77, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    check("write_drop_pulse", 32'(o_drop[0]), 32'd1);
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
    run_until_idle(n);
    check("clear_busy_len", 32'(n + 1), 32'd4);
    check("drop_one_cycle", 32'(o_drop[0]), 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 2'd0, 8'h00, 1'b1, 2'(a), 2'(3 - a), 1'b0);
      tick();
    end

    // clear_req re-asserted mid-sweep does not extend it.
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b1);
    tick();
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
    run_until_idle(n);
    check("clear_reassert_len", 32'(n + 1), 32'd4);

    // Reset on sweep cycle 2 restarts a full sweep.
    drive(1'b1, 2'd2, 8'h5A, 1'b0, 2'd0, 2'd0, 1'b1);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run_until_idle(n);
    check("reset_mid_sweep_len", 32'(n), 32'd4);

    // read_en=0 holds outputs while array and addresses change.
    drive(1'b1, 2'd1, 8'h9C, 1'b1, 2'd1, 2'd1, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 8'(8'h30 + i), 1'b0, 2'(i), 2'(3 - i), 1'b0);
      tick();
    end
    check("hold_rd1", 32'(o_rd1[0]), 32'h09C);
    check("hold_rd2", 32'(o_rd2[0]), 32'h09C);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(1)), 2'($urandom), 8'($urandom), 1'($urandom_range(3) != 0),
            2'($urandom), 2'($urandom), 1'($urandom_range(15) == 0));
      rst_n = ($urandom_range(63) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
